inverse_color_transform: RTL and testbench
==========================================

INVERSE_COLOR_TRANSFORM -- requirements
Module: inverse_color_transform

Interface
REQ-001 SHALL have parameter ADDR_W, default 20: SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16: SRAM data width.
REQ-003 clk  input  1  the only clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_inverse  input  1  single-cycle start request.
REQ-006 iCol_Max  input  10  frame width in pixels.
REQ-007 iRow_Max  input  10  frame height in pixels.
REQ-008 oSRAM_OE_N  output  1  SRAM read enable, active low.
REQ-009 oSRAM_WE_N  output  1  SRAM write enable, active low.
REQ-010 oSRAM_ADDR  output  ADDR_W  SRAM word address.
REQ-011 ioSRAM_DATA  inout  DATA_W  SRAM data bus.
REQ-012 oStore_g  output  2  current plane phase: 0 idle, 1 Y/R, 2 U/G, 3 V/B.
REQ-013 oBusy  output  1  high while a frame is in progress.
REQ-014 oDone  output  1  one-cycle pulse at frame end.
REQ-015 oErr  output  1  sticky flag: last start was rejected; cleared by the next accepted start.

Function
REQ-016 Plane size SHALL be N = iRow_Max*iCol_Max (20-bit); both sizes SHALL be latched on the accepted start.
REQ-017 Input planes SHALL be: Y at address k, U at N+k, V at 2N+k, for pixel k in 0..N-1.
REQ-018 Y SHALL be taken from bits [7:0]; U and V SHALL be 16-bit two's complement values.
REQ-019 The block SHALL compute G = Y - ((U+V)>>>2), R = V + G, B = U + G, using 11-bit signed arithmetic and an arithmetic (floor) shift.
REQ-020 Results SHALL be written in place as {8'h00,byte}: R to k, G to N+k, B to 2N+k.
REQ-021 The FSM SHALL have the states IDLE, RD_Y, RD_U, RD_V, CALC, WR_R, WR_G, WR_B, FIN.
REQ-022 Per pixel, states SHALL run RD_Y, RD_U, RD_V, CALC, WR_R, WR_G, WR_B, i.e. 7 cycles.
REQ-023 After WR_B, the FSM SHALL go to RD_Y with k+1 if k<N-1, else to FIN; FIN SHALL go to IDLE.
REQ-024 In an RD state, OE_N SHALL be 0, WE_N 1, and ADDR valid; the bus SHALL be sampled at the closing edge.
REQ-025 In a WR state, WE_N SHALL be 0, OE_N 1, and the bus SHALL be driven; in all other states the bus SHALL be high-Z.
REQ-026 oStore_g SHALL be 1/2/3 in RD_Y or WR_R / RD_U or WR_G / RD_V or WR_B, SHALL hold its value in CALC, and SHALL be 0 in IDLE and FIN.
REQ-027 oBusy SHALL be high in every state except IDLE; oDone SHALL be high only in FIN.
REQ-028 start_inverse SHALL be ignored when the FSM is not in IDLE.
REQ-029 A start with N==0 or 3N > 2^ADDR_W SHALL perform no SRAM access, go IDLE->FIN, and set oErr.
REQ-030 Total busy time SHALL be 7N+1 cycles, counting the FIN cycle.

Reset
REQ-031 rst, including mid-frame, SHALL force on the next edge: IDLE, OE_N=1, WE_N=1, ADDR=0, bus high-Z, oStore_g=0, oBusy=0, oDone=0, oErr=0, k=0.
REQ-032 A reset during a WR state SHALL abort that write; a partially written frame SHALL NOT be resumed.

Configuration
REQ-033 With ICT_CLAMP_EN defined, R, G and B SHALL saturate to 0..255.
REQ-034 Without ICT_CLAMP_EN, R, G and B SHALL be truncated to bits [7:0].

Structure
REQ-035 Package ict_pkg SHALL hold the state enum, the plane-phase constants (0..3) and CH_W=8.
REQ-036 Sub-module ict_core SHALL hold the combinational inverse RCT plus the clamp/truncate stage, fed from the Y/U/V registers in CALC.

Verification
REQ-037 Y=100, U=FFEC, V=001E -> R=128, G=98, B=78 (words 0080/0062/004E).
REQ-038 Y=250, U=0, V=100 -> G=225, B=225; R=255 with ICT_CLAMP_EN, R=69 (0x45) without.
REQ-039 Y=10, U=FFFD, V=0 (floor check) -> G=11, R=11, B=8.
REQ-040 Row=2, Col=2 -> reads 0,4,8 then writes 0,4,8 for pixel 0; oBusy high 29 cycles; single oDone.
REQ-041 start_inverse pulsed mid-frame, then rst asserted in WR_G -> start ignored; next cycle all outputs at reset values and bus high-Z.
REQ-042 Row=0, Col=40 -> no OE_N/WE_N activity, oDone one cycle after start, oErr=1.

Source files
------------

// File: rtl/ict_pkg.sv
// Shared types and constants for the inverse colour transform block.
package ict_pkg;

  localparam int CH_W   = 8;
  localparam int CALC_W = 11;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_Y    = 2'd1;
  localparam logic [1:0] PH_U    = 2'd2;
  localparam logic [1:0] PH_V    = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    RD_Y,
    RD_U,
    RD_V,
    CALC,
    WR_R,
    WR_G,
    WR_B,
    FIN
  } ict_state_e;

endpackage

// File: rtl/ict_core.sv
// Combinational inverse RCT (Y/U/V -> R/G/B) with output fitting stage.
// Define ICT_CLAMP_EN to saturate results to 0..255 instead of truncating.
module ict_core
  import ict_pkg::*;
(
  input  logic [CH_W-1:0]          y,
  input  logic signed [CALC_W-1:0] u,
  input  logic signed [CALC_W-1:0] v,
  output logic [CH_W-1:0]          r,
  output logic [CH_W-1:0]          g,
  output logic [CH_W-1:0]          b
);

  function automatic logic [CH_W-1:0] fit_ch(input logic signed [CALC_W-1:0] x);
`ifdef ICT_CLAMP_EN
    if (x[CALC_W-1])
      return '0;
    else if (x > CALC_W'(255))
      return {CH_W{1'b1}};
    else
      return x[CH_W-1:0];
`else
    return x[CH_W-1:0];
`endif
  endfunction

  logic signed [CALC_W-1:0] y_s;
  logic signed [CALC_W-1:0] uv_sum;
  logic signed [CALC_W-1:0] g_s;
  logic signed [CALC_W-1:0] r_s;
  logic signed [CALC_W-1:0] b_s;

  // Everything wraps in CALC_W bits; the shift floors toward minus infinity.
  always_comb begin
    y_s    = $signed({{(CALC_W-CH_W){1'b0}}, y});
    uv_sum = u + v;
    g_s    = y_s - (uv_sum >>> 2);
    r_s    = v + g_s;
    b_s    = u + g_s;
  end

  assign r = fit_ch(r_s);
  assign g = fit_ch(g_s);
  assign b = fit_ch(b_s);

endmodule

// File: rtl/inverse_color_transform.sv
// In-place SRAM inverse colour transform: reads Y/U/V planes, writes R/G/B back.
// Optional ICT_CLAMP_EN selects saturating output instead of truncation.
module inverse_color_transform
  import ict_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_inverse,
  input  logic [9:0]        iCol_Max,
  input  logic [9:0]        iRow_Max,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_WE_N,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  inout  wire  [DATA_W-1:0] ioSRAM_DATA,
  output logic [1:0]        oStore_g,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam int EXT_W = (ADDR_W + 2 > 24) ? ADDR_W + 2 : 24;
  localparam logic [EXT_W-1:0] SPAN = EXT_W'(1) << ADDR_W;

  ict_state_e state, state_nxt;

  logic [19:0]       n_q, k_q, n_req;
  logic [EXT_W-1:0]  n_req3;
  logic              req_bad, k_last, err_q;
  logic              rd_en, wr_en, wr_act;
  logic [1:0]        phase;
  logic [ADDR_W-1:0] k_a, n_a, base, addr;

  logic [CH_W-1:0]          y_p0;
  logic signed [CALC_W-1:0] u_p0, v_p0;
  logic [CH_W-1:0]          r_c, g_c, b_c;
  logic [CH_W-1:0]          r_p1, g_p1, b_p1, wr_byte;
  logic                     unused_bus_hi;

  assign n_req   = 20'(iRow_Max) * 20'(iCol_Max);
  assign n_req3  = EXT_W'(n_req) + (EXT_W'(n_req) << 1);
  assign req_bad = (n_req == '0) || (n_req3 > SPAN);
  assign k_last  = (k_q == n_q - 20'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k_q   <= '0;
      n_q   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_inverse) begin
        err_q <= req_bad;
        k_q   <= '0;
        if (!req_bad) n_q <= n_req;
      end else if (state == WR_B && !k_last) begin
        k_q <= k_q + 20'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    phase     = PH_IDLE;
    case (state)
      IDLE: if (start_inverse) state_nxt = req_bad ? FIN : RD_Y;
      RD_Y: begin rd_en = 1'b1; phase = PH_Y; state_nxt = RD_U; end
      RD_U: begin rd_en = 1'b1; phase = PH_U; state_nxt = RD_V; end
      RD_V: begin rd_en = 1'b1; phase = PH_V; state_nxt = CALC; end
      CALC: begin phase = PH_V; state_nxt = WR_R; end
      WR_R: begin wr_en = 1'b1; phase = PH_Y; state_nxt = WR_G; end
      WR_G: begin wr_en = 1'b1; phase = PH_U; state_nxt = WR_B; end
      WR_B: begin wr_en = 1'b1; phase = PH_V; state_nxt = k_last ? FIN : RD_Y; end
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign k_a = ADDR_W'(k_q);
  assign n_a = ADDR_W'(n_q);

  always_comb begin
    base = '0;
    case (state)
      RD_U, WR_G: base = n_a;
      RD_V, WR_B: base = n_a << 1;
      default:    base = '0;
    endcase
  end

  assign addr = base + k_a;

  // Read stage: capture the bus at the closing edge of each RD state.
  always_ff @(posedge clk) begin
    if (state == RD_Y) y_p0 <= ioSRAM_DATA[CH_W-1:0];
    if (state == RD_U) u_p0 <= $signed(ioSRAM_DATA[CALC_W-1:0]);
    if (state == RD_V) v_p0 <= $signed(ioSRAM_DATA[CALC_W-1:0]);
  end

  assign unused_bus_hi = ^ioSRAM_DATA[DATA_W-1:CALC_W];

  ict_core u_core (
    .y (y_p0),
    .u (u_p0),
    .v (v_p0),
    .r (r_c),
    .g (g_c),
    .b (b_c)
  );

  // Result stage: hold the transformed pixel for the three write cycles.
  always_ff @(posedge clk) begin
    if (state == CALC) begin
      r_p1 <= r_c;
      g_p1 <= g_c;
      b_p1 <= b_c;
    end
  end

  always_comb begin
    wr_byte = r_p1;
    case (state)
      WR_G:    wr_byte = g_p1;
      WR_B:    wr_byte = b_p1;
      default: wr_byte = r_p1;
    endcase
  end

  // Reset drops the write strobe immediately so an in-flight write never lands.
  assign wr_act      = wr_en && !rst;
  assign ioSRAM_DATA = wr_act ? {{(DATA_W-CH_W){1'b0}}, wr_byte} : {DATA_W{1'bz}};
  assign oSRAM_OE_N  = !rd_en;
  assign oSRAM_WE_N  = !wr_act;
  assign oSRAM_ADDR  = (rd_en || wr_en) ? addr : '0;
  assign oStore_g    = phase;
  assign oBusy       = (state != IDLE);
  assign oDone       = (state == FIN);
  assign oErr        = err_q;

endmodule

// File: tb/tb_inverse_color_transform.sv
// Directed bench for inverse_color_transform with a small behavioural SRAM.
`timescale 1ns/1ps
module tb_inverse_color_transform;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
`ifdef ICT_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start_inverse;
  logic [9:0]        iCol_Max, iRow_Max;
  logic              oSRAM_OE_N, oSRAM_WE_N;
  logic [ADDR_W-1:0] oSRAM_ADDR;
  wire  [DATA_W-1:0] sram_data;
  logic [1:0]        oStore_g;
  logic              oBusy, oDone, oErr;

  logic [15:0] mem [0:63];

  int n_chk  = 0;
  int n_fail = 0;
  int busy_cnt, done_cnt, cyc, phase_bad, oob, cur_n;
  int log_addr[$];
  bit log_wr[$];

  typedef struct {
    logic [7:0]  y;
    logic [15:0] u;
    logic [15:0] v;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } vec_t;

  vec_t vec [7];

  inverse_color_transform #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_inverse (start_inverse),
    .iCol_Max      (iCol_Max),
    .iRow_Max      (iRow_Max),
    .oSRAM_OE_N    (oSRAM_OE_N),
    .oSRAM_WE_N    (oSRAM_WE_N),
    .oSRAM_ADDR    (oSRAM_ADDR),
    .ioSRAM_DATA   (sram_data),
    .oStore_g      (oStore_g),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oErr          (oErr)
  );

  always #5 clk = ~clk;

  // SRAM returns data while OE_N is low; otherwise it holds the bus at zero
  // when nobody should be writing, so a stray DUT driver shows up as non-zero.
  assign sram_data = oSRAM_WE_N ? (oSRAM_OE_N ? 16'h0000 : mem[oSRAM_ADDR[5:0]]) : 16'hzzzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    int exp_ph;
    @(posedge clk);
    if (!oSRAM_WE_N) begin
      if (oSRAM_ADDR < 20'd64) mem[oSRAM_ADDR[5:0]] = sram_data;
      else oob++;
    end
    @(negedge clk);
    cyc++;
    if (oBusy) busy_cnt++;
    if (oDone) done_cnt++;
    if (!oSRAM_OE_N || !oSRAM_WE_N) begin
      log_addr.push_back(int'(oSRAM_ADDR));
      log_wr.push_back(!oSRAM_WE_N);
      if (!oSRAM_OE_N && !oSRAM_WE_N) phase_bad++;
      if (int'(oSRAM_ADDR) < cur_n) exp_ph = 1;
      else if (int'(oSRAM_ADDR) < 2 * cur_n) exp_ph = 2;
      else exp_ph = 3;
      if (int'(oStore_g) != exp_ph) phase_bad++;
    end else if (oBusy && !oDone) begin
      if (oStore_g != 2'd3) phase_bad++;
    end else if (oStore_g != 2'd0) begin
      phase_bad++;
    end
  endtask

  task automatic clear_mon();
    busy_cnt = 0; done_cnt = 0; cyc = 0; phase_bad = 0; oob = 0;
    log_addr.delete();
    log_wr.delete();
  endtask

  task automatic run_frame(input int rows, input int cols, input int budget,
                           output int done_at, output bit timed_out);
    clear_mon();
    cur_n         = rows * cols;
    iRow_Max      = 10'(rows);
    iCol_Max      = 10'(cols);
    start_inverse = 1'b1;
    step();
    start_inverse = 1'b0;
    while (done_cnt == 0 && cyc < budget) step();
    timed_out = (done_cnt == 0);
    done_at   = cyc;
    step();
  endtask

  task automatic load_pixels(input int n);
    for (int k = 0; k < n; k++) begin
      mem[k]       = {8'hAB, vec[k].y};
      mem[n + k]   = vec[k].u;
      mem[2*n + k] = vec[k].v;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_oe_n"},  32'(oSRAM_OE_N), 1);
    chk({tag, "_we_n"},  32'(oSRAM_WE_N), 1);
    chk({tag, "_addr"},  32'(oSRAM_ADDR), 0);
    chk({tag, "_bus"},   32'(sram_data),  0);
    chk({tag, "_store"}, 32'(oStore_g),   0);
    chk({tag, "_busy"},  32'(oBusy),      0);
    chk({tag, "_done"},  32'(oDone),      0);
    chk({tag, "_err"},   32'(oErr),       0);
  endtask

  initial begin
    int   done_at;
    bit   to;
    bit   found;
    logic [15:0] u0_orig;

    vec[0] = '{8'd100, 16'hFFEC, 16'h001E, 8'd128, 8'd98, 8'd78};
    vec[1] = '{8'd250, 16'h0000, 16'h0064, CLAMP ? 8'd255 : 8'd69, 8'd225, 8'd225};
    vec[2] = '{8'd10,  16'hFFFD, 16'h0000, 8'd11, 8'd11, 8'd8};
    vec[3] = '{8'd128, 16'h0010, 16'hFFF0, 8'd112, 8'd128, 8'd144};
    vec[4] = '{8'd0,   16'h0064, 16'h0000, CLAMP ? 8'd0 : 8'd231, CLAMP ? 8'd0 : 8'd231, 8'd75};
    vec[5] = '{8'd255, 16'hFF9C, 16'hFF9C, 8'd205, CLAMP ? 8'd255 : 8'd49, 8'd205};
    vec[6] = '{8'd0,   16'h0000, 16'h0000, 8'd0, 8'd0, 8'd0};

    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    rst = 1'b1; start_inverse = 1'b0; iRow_Max = '0; iCol_Max = '0;
    cur_n = 0;
    clear_mon();
    repeat (3) step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Single-pixel frames, one per vector.
    for (int i = 0; i < 7; i++) begin
      mem[0] = {8'hAB, vec[i].y};
      mem[1] = vec[i].u;
      mem[2] = vec[i].v;
      run_frame(1, 1, 50, done_at, to);
      chk($sformatf("px%0d_timeout", i), 32'(to), 0);
      chk($sformatf("px%0d_R", i), 32'(mem[0]), {24'h0, vec[i].r});
      chk($sformatf("px%0d_G", i), 32'(mem[1]), {24'h0, vec[i].g});
      chk($sformatf("px%0d_B", i), 32'(mem[2]), {24'h0, vec[i].b});
      chk($sformatf("px%0d_busy", i), 32'(busy_cnt), 8);
      chk($sformatf("px%0d_phase", i), 32'(phase_bad), 0);
    end

    // 2x2 frame: access order, busy length, done pulse and all results.
    load_pixels(4);
    run_frame(2, 2, 100, done_at, to);
    chk("f4_timeout", 32'(to), 0);
    chk("f4_accesses", 32'(log_addr.size()), 24);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("f4_acc%0d_addr", j), 32'(log_addr[j]), 32'((j % 3) * 4));
      chk($sformatf("f4_acc%0d_wr", j), 32'(log_wr[j]), (j >= 3) ? 1 : 0);
    end
    chk("f4_busy", 32'(busy_cnt), 29);
    chk("f4_done", 32'(done_cnt), 1);
    chk("f4_phase", 32'(phase_bad), 0);
    chk("f4_oob", 32'(oob), 0);
    chk("f4_err", 32'(oErr), 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("f4_R%0d", k), 32'(mem[k]),     {24'h0, vec[k].r});
      chk($sformatf("f4_G%0d", k), 32'(mem[4 + k]), {24'h0, vec[k].g});
      chk($sformatf("f4_B%0d", k), 32'(mem[8 + k]), {24'h0, vec[k].b});
    end

    // Mid-frame start is ignored, then reset lands during WR_G of pixel 0.
    load_pixels(4);
    u0_orig = mem[4];
    clear_mon();
    cur_n = 4; iRow_Max = 10'd2; iCol_Max = 10'd2;
    start_inverse = 1'b1;
    step();
    start_inverse = 1'b0;
    repeat (3) step();
    iRow_Max = 10'd0;
    start_inverse = 1'b1;
    step();
    start_inverse = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (!oSRAM_WE_N && oSRAM_ADDR == 20'd4) found = 1'b1;
      else step();
    end
    chk("rstmid_wrg_reached", 32'(found), 1);
    chk("rstmid_start_ignored_err", 32'(oErr), 0);
    chk("rstmid_start_ignored_busy", 32'(oBusy), 1);
    rst = 1'b1;
    step();
    chk_idle_outputs("rstmid");
    rst = 1'b0;
    chk("rstmid_wr_aborted", 32'(mem[4]), 32'(u0_orig));
    chk("rstmid_wr_r_done", 32'(mem[0]), {24'h0, vec[0].r});
    clear_mon();
    repeat (10) step();
    chk("rstmid_no_resume_busy", 32'(busy_cnt), 0);
    chk("rstmid_no_resume_acc", 32'(log_addr.size()), 0);

    // Rejected starts: empty frame and a frame too large for the address space.
    run_frame(0, 40, 20, done_at, to);
    chk("zero_timeout", 32'(to), 0);
    chk("zero_done_at", 32'(done_at), 1);
    chk("zero_accesses", 32'(log_addr.size()), 0);
    chk("zero_busy", 32'(busy_cnt), 1);
    chk("zero_done", 32'(done_cnt), 1);
    chk("zero_err", 32'(oErr), 1);
    run_frame(1023, 1023, 20, done_at, to);
    chk("big_done_at", 32'(done_at), 1);
    chk("big_accesses", 32'(log_addr.size()), 0);
    chk("big_err", 32'(oErr), 1);

    // A good start clears the sticky error.
    mem[0] = {8'hAB, vec[2].y};
    mem[1] = vec[2].u;
    mem[2] = vec[2].v;
    run_frame(1, 1, 50, done_at, to);
    chk("clr_timeout", 32'(to), 0);
    chk("clr_err", 32'(oErr), 0);
    chk("clr_B", 32'(mem[2]), {24'h0, vec[2].b});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
